fir_deconv: RTL and testbench

Inverse (deconvolution) stage for the 3-tap FIR datapath. It accepts 16-bit filter output samples y[n] produced with coefficients H0/H1/H2 and recovers the 8-bit unsigned input samples x[n] = (y[n] − H1·x[n−1] − H2·x[n−2]) / H0. It sits at the receive end of a link carrying FIR output, or in a loopback bench behind the FIR, and uses a multi-cycle restoring divider with valid/ready handshakes on both sides.

---
 rtl/fir_deconv.sv | 140 ++++++++++++++
 tb/tb_fir_deconv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fir_deconv.sv
// Deconvolution stage for the 3-tap FIR: recovers x[n] = (y[n] - H1*x[n-1] - H2*x[n-2]) / H0
// with a 16-cycle restoring divider. Define FIR_DECONV_SAT_EN to clamp out-of-range results.
module fir_deconv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] y_in,
  input  logic        y_valid,
  output logic        y_ready,
  input  logic [7:0]  H0,
  input  logic [7:0]  H1,
  input  logic [7:0]  H2,
  output logic [7:0]  x_out,
  output logic        x_valid,
  input  logic        x_ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CALC, DIV, OUT} state_t;

  state_t      state, state_next;
  logic [15:0] y_r;
  logic [7:0]  h0_r, h1_r, h2_r;
  logic [7:0]  xp1, xp2;
  logic [15:0] dq;
  logic [7:0]  rem;
  logic [3:0]  cnt;
  logic        neg;

  logic [15:0] p1, p2;
  logic [17:0] resid;
  logic        rneg;
  logic [8:0]  trial;
  logic        qbit;
  logic [7:0]  diff;
  logic [7:0]  rem_next;
  logic [15:0] q_final;
  logic        over;
  logic [7:0]  x_final;

  // Residual fits 18 bits signed; a non-negative residual never exceeds 16 bits,
  // so any set bit above bit 15 means the residual went negative.
  assign p1    = {8'd0, h1_r} * {8'd0, xp1};
  assign p2    = {8'd0, h2_r} * {8'd0, xp2};
  assign resid = {2'b00, y_r} - {2'b00, p1} - {2'b00, p2};
  assign rneg  = (resid[17:16] != 2'b00);

  // One restoring step: dq shifts the dividend out MSB-first and the quotient in LSB-first.
  assign trial    = {rem, dq[15]};
  assign qbit     = (trial >= {1'b0, h0_r});
  assign diff     = 8'(trial - {1'b0, h0_r});
  assign rem_next = qbit ? diff : trial[7:0];
  assign q_final  = {dq[14:0], qbit};
  assign over     = (q_final[15:8] != 8'd0);

`ifdef FIR_DECONV_SAT_EN
  assign x_final = neg ? 8'd0 : (over ? 8'd255 : q_final[7:0]);
`else
  assign x_final = q_final[7:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    y_ready    = 1'b0;
    case (state)
      IDLE: begin
        y_ready = 1'b1;
        if (y_valid) state_next = CALC;
      end
      CALC:    state_next = (h0_r == 8'd0) ? OUT : DIV;
      DIV:     if (cnt == 4'd15) state_next = OUT;
      OUT:     if (x_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_r     <= '0;
      h0_r    <= '0;
      h1_r    <= '0;
      h2_r    <= '0;
      xp1     <= '0;
      xp2     <= '0;
      dq      <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      x_out   <= '0;
      x_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (y_valid) begin
            y_r  <= y_in;
            h0_r <= H0;
            h1_r <= H1;
            h2_r <= H2;
          end
        end
        CALC: begin
          dq  <= resid[15:0];
          rem <= '0;
          cnt <= '0;
          neg <= rneg;
          if (h0_r == 8'd0) begin
            x_out   <= 8'd0;
            err     <= 1'b1;
            x_valid <= 1'b1;
          end
        end
        DIV: begin
          dq  <= q_final;
          rem <= rem_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            x_out   <= x_final;
            err     <= neg | over;
            x_valid <= 1'b1;
          end
        end
        OUT: begin
          // History takes the value actually emitted, including clamped or error results.
          if (x_ready) begin
            x_valid <= 1'b0;
            xp2     <= xp1;
            xp1     <= x_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_deconv.sv
// Directed, table-driven bench for fir_deconv; expectations follow FIR_DECONV_SAT_EN when defined.
module tb_fir_deconv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] y_in;
  logic        y_valid;
  logic        y_ready;
  logic [7:0]  H0, H1, H2;
  logic [7:0]  x_out;
  logic        x_valid;
  logic        x_ready;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [15:0] y;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [7:0]  h2;
    logic [7:0]  ex;
    logic        ee;
  } vec_t;

  vec_t vecs [11];

  fir_deconv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .y_in    (y_in),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .H0      (H0),
    .H1      (H1),
    .H2      (H2),
    .x_out   (x_out),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one sample at a negedge, measures cycles to x_valid, optionally stalls x_ready, then hands off.
  task automatic applyStimulus(input vec_t v, input string name, input int hold);
    int lat;
    int expLat;
    checkOutput({name, "_yready_pre"}, int'(y_ready), 1);
    y_in    = v.y;
    H0      = v.h0;
    H1      = v.h1;
    H2      = v.h2;
    y_valid = 1'b1;
    lat     = 0;
    do begin
      @(negedge clk);
      y_valid = 1'b0;
      lat++;
    end while (!x_valid && lat < 40);
    expLat = (v.h0 == 8'd0) ? 2 : 18;
    checkOutput({name, "_latency"}, lat, expLat);
    if (!x_valid) return;
    checkOutput({name, "_x"}, int'(x_out), int'(v.ex));
    checkOutput({name, "_err"}, int'(err), int'(v.ee));
    for (int i = 0; i < hold; i++) begin
      y_in    = 16'd500;
      H0      = 8'd1;
      H1      = 8'd0;
      H2      = 8'd0;
      y_valid = 1'b1;
      @(negedge clk);
      checkOutput({name, "_hold_valid"}, int'(x_valid), 1);
      checkOutput({name, "_hold_x"}, int'(x_out), int'(v.ex));
      checkOutput({name, "_hold_err"}, int'(err), int'(v.ee));
      checkOutput({name, "_hold_yready"}, int'(y_ready), 0);
    end
    y_valid = 1'b0;
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    checkOutput({name, "_post_valid"}, int'(x_valid), 0);
    checkOutput({name, "_post_yready"}, int'(y_ready), 1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{y: 16'd10,    h0: 8'd2,   h1: 8'd3,  h2: 8'd1, ex: 8'd5,   ee: 1'b0};
    vecs[1] = '{y: 16'd29,    h0: 8'd2,   h1: 8'd3,  h2: 8'd1, ex: 8'd7,   ee: 1'b0};
    vecs[2] = '{y: 16'd44,    h0: 8'd2,   h1: 8'd3,  h2: 8'd1, ex: 8'd9,   ee: 1'b0};
`ifdef FIR_DECONV_SAT_EN
    vecs[3] = '{y: 16'd300,   h0: 8'd1,   h1: 8'd0,  h2: 8'd0, ex: 8'd255, ee: 1'b1};
`else
    vecs[3] = '{y: 16'd300,   h0: 8'd1,   h1: 8'd0,  h2: 8'd0, ex: 8'd44,  ee: 1'b1};
`endif
    vecs[4] = '{y: 16'd100,   h0: 8'd0,   h1: 8'd0,  h2: 8'd0, ex: 8'd0,   ee: 1'b1};
    // H1 nonzero here only yields 5 if the H0==0 result really cleared x[n-1].
    vecs[5] = '{y: 16'd5,     h0: 8'd1,   h1: 8'd7,  h2: 8'd0, ex: 8'd5,   ee: 1'b0};
`ifdef FIR_DECONV_SAT_EN
    vecs[6] = '{y: 16'd20,    h0: 8'd1,   h1: 8'd10, h2: 8'd0, ex: 8'd0,   ee: 1'b1};
`else
    vecs[6] = '{y: 16'd20,    h0: 8'd1,   h1: 8'd10, h2: 8'd0, ex: 8'd226, ee: 1'b1};
`endif
    vecs[7] = '{y: 16'd25,    h0: 8'd3,   h1: 8'd0,  h2: 8'd2, ex: 8'd5,   ee: 1'b0};
    vecs[8] = '{y: 16'd27,    h0: 8'd4,   h1: 8'd1,  h2: 8'd0, ex: 8'd5,   ee: 1'b0};
`ifdef FIR_DECONV_SAT_EN
    vecs[9] = '{y: 16'd65535, h0: 8'd255, h1: 8'd0,  h2: 8'd0, ex: 8'd255, ee: 1'b1};
`else
    vecs[9] = '{y: 16'd65535, h0: 8'd255, h1: 8'd0,  h2: 8'd0, ex: 8'd1,   ee: 1'b1};
`endif
    vecs[10] = '{y: 16'd65025, h0: 8'd255, h1: 8'd0, h2: 8'd0, ex: 8'd255, ee: 1'b0};

    rst_n   = 1'b0;
    y_in    = '0;
    y_valid = 1'b0;
    H0      = '0;
    H1      = '0;
    H2      = '0;
    x_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_yready", int'(y_ready), 1);
    checkOutput("reset_xvalid", int'(x_valid), 0);
    checkOutput("reset_xout", int'(x_out), 0);
    checkOutput("reset_err", int'(err), 0);

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 0);

    v = '{y: 16'd77, h0: 8'd1, h1: 8'd0, h2: 8'd0, ex: 8'd77, ee: 1'b0};
    applyStimulus(v, "stall", 10);
    v = '{y: 16'd80, h0: 8'd1, h1: 8'd1, h2: 8'd0, ex: 8'd3, ee: 1'b0};
    applyStimulus(v, "after_stall", 0);

    // Abort in the eighth divide cycle; history holds 3 going in, so a stale xp1 would corrupt the retry.
    y_in    = 16'd100;
    H0      = 8'd2;
    H1      = 8'd3;
    H2      = 8'd1;
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("middiv_rst_xvalid", int'(x_valid), 0);
    checkOutput("middiv_rst_yready", int'(y_ready), 1);
    checkOutput("middiv_rst_xout", int'(x_out), 0);
    checkOutput("middiv_rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{y: 16'd10, h0: 8'd2, h1: 8'd3, h2: 8'd1, ex: 8'd5, ee: 1'b0};
    applyStimulus(v, "post_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
